// File: rtl/mdu_pkg.sv
// Shared op codes, op-class decode helpers and the FSM state type for the
// multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MADD  = 4'd5;
  localparam logic [3:0] MD_MADDU = 4'd6;
  localparam logic [3:0] MD_MSUB  = 4'd7;
  localparam logic [3:0] MD_MSUBU = 4'd8;
  localparam logic [3:0] MD_MTHI  = 4'd9;
  localparam logic [3:0] MD_MTLO  = 4'd10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU};
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// EX-stage request/result bundle between the pipeline controller and the
// multiply/divide unit.
interface mul_div_unit_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);
  // Handshake: Start is a one-cycle valid sampled at the rising edge; the unit
  // is ready only while Busy=0. Start with Busy=1 is illegal unless Flush is
  // also high, and Flush always overrides Start in the same cycle.
  logic             Start;
  logic [3:0]       Op;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             Flush;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  mdu_state_e       dbg_state;

  modport master (
    output Start, Op, Operand1, Operand2, Flush,
    input  Busy, HI, LO, dbg_state
  );

  modport slave (
    input  Start, Op, Operand1, Operand2, Flush,
    output Busy, HI, LO, dbg_state
  );
endinterface

// File: rtl/md_arith.sv
// Combinational datapath: next {HI,LO} for the latched operation plus a
// divide-by-zero flag. Division works on magnitudes so MIN/-1 wraps cleanly.
module md_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_hi,
  input  logic [WIDTH-1:0]   i_lo,
  output logic [2*WIDTH-1:0] o_hilo,
  output logic               o_div_by_zero
);

  logic [2*WIDTH-1:0] w_sa, w_sb, w_ua, w_ub;
  logic [2*WIDTH-1:0] w_prod_s, w_prod_u, w_acc;
  logic               w_div_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_b_safe;
  logic [WIDTH-1:0]   w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_sa     = {{WIDTH{i_a[WIDTH-1]}}, i_a};
  assign w_sb     = {{WIDTH{i_b[WIDTH-1]}}, i_b};
  assign w_ua     = {{WIDTH{1'b0}}, i_a};
  assign w_ub     = {{WIDTH{1'b0}}, i_b};
  assign w_prod_s = w_sa * w_sb;
  assign w_prod_u = w_ua * w_ub;
  assign w_acc    = {i_hi, i_lo};

  assign w_div_signed = (i_op == MD_DIV);
  assign w_a_neg      = w_div_signed & i_a[WIDTH-1];
  assign w_b_neg      = w_div_signed & i_b[WIDTH-1];
  assign w_a_mag      = w_a_neg ? -i_a : i_a;
  assign w_b_mag      = w_b_neg ? -i_b : i_b;
  // A zero divisor is swapped for 1 only to keep the divider defined; the
  // result is discarded via o_div_by_zero.
  assign w_b_safe     = (w_b_mag == '0) ? WIDTH'(1) : w_b_mag;
  assign w_q_mag      = w_a_mag / w_b_safe;
  assign w_r_mag      = w_a_mag % w_b_safe;
  assign w_quot       = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
  assign w_rem        = w_a_neg ? -w_r_mag : w_r_mag;

  assign o_div_by_zero = is_div_op(i_op) && (i_b == '0);

  always_comb begin
    o_hilo = w_acc;
    case (i_op)
      MD_MULT:          o_hilo = w_prod_s;
      MD_MULTU:         o_hilo = w_prod_u;
      MD_MADD:          o_hilo = w_acc + w_prod_s;
      MD_MADDU:         o_hilo = w_acc + w_prod_u;
      MD_MSUB:          o_hilo = w_acc - w_prod_s;
      MD_MSUBU:         o_hilo = w_acc - w_prod_u;
      MD_DIV, MD_DIVU:  o_hilo = {w_rem, w_quot};
      default:          o_hilo = w_acc;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// A down-counter models the latency; results commit on the cnt==1 edge.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0]   w_hi_nxt, w_lo_nxt;
  logic               w_latch, w_div_by_zero;
  logic [2*WIDTH-1:0] w_hilo;
  mdu_state_e         w_state;

  md_arith #(.WIDTH(WIDTH)) u_arith (
    .i_op          (r_op),
    .i_a           (r_a),
    .i_b           (r_b),
    .i_hi          (r_hi),
    .i_lo          (r_lo),
    .o_hilo        (w_hilo),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_state       = (r_cnt != '0) ? ST_RUN : ST_IDLE;
  assign bus.Busy      = (r_cnt != '0);
  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;
  assign bus.dbg_state = w_state;

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    w_latch   = 1'b0;
    if (bus.Flush) begin
      w_cnt_nxt = '0;
    end else begin
      case (w_state)
        ST_IDLE: begin
          if (bus.Start) begin
            if (is_mul_op(bus.Op)) begin
              w_cnt_nxt = CNT_W'(MUL_LAT);
              w_latch   = 1'b1;
            end else if (is_div_op(bus.Op)) begin
              w_cnt_nxt = CNT_W'(DIV_LAT);
              w_latch   = 1'b1;
            end else if (bus.Op == MD_MTHI) begin
              w_hi_nxt = bus.Operand1;
            end else if (bus.Op == MD_MTLO) begin
              w_lo_nxt = bus.Operand1;
            end
          end
        end
        ST_RUN: begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if ((r_cnt == CNT_W'(1)) && !w_div_by_zero) begin
            w_hi_nxt = w_hilo[2*WIDTH-1:WIDTH];
            w_lo_nxt = w_hilo[WIDTH-1:0];
          end
        end
        default: w_cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_op  <= MD_NONE;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      if (w_latch) begin
        r_op <= bus.Op;
        r_a  <= bus.Operand1;
        r_b  <= bus.Operand2;
      end
    end
  end

endmodule
